// File: rtl/mmc3_ss_seq.sv
// Save-state sequencer: walks the MMC3 ss map, SAVE copies registers into a 16x8 buffer, RESTORE writes them back.
// Latency: SAVE 16*(RD_SETTLE+2) clk; RESTORE 3 clk + 15 writes, each aligned to a synchronised m2 fall.
// Backpressure: none upstream (start ignored while busy); RESTORE stalls on m2 and aborts with err after M2_TMO clk.
module mmc3_ss_seq #(
  parameter int unsigned RD_SETTLE = 2,
  parameter int unsigned POST_HOLD = 2,
  parameter int unsigned M2_TMO    = 64,
  parameter logic [7:0]  MAP_IDX   = 8'd4
) (
  input  logic       clk,
  input  logic       map_rst,
  input  logic       start,
  input  logic       dir,
  output logic       busy,
  output logic       done,
  output logic       err,
  input  logic       m2,
  output logic       ss_act,
  output logic       ss_we,
  output logic [7:0] ss_addr,
  output logic [7:0] ss_wdat,
  input  logic [7:0] ss_rdat,
  output logic [3:0] buf_addr,
  output logic       buf_we,
  output logic [7:0] buf_wdat,
  input  logic [7:0] buf_rdat
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_SETTLE,
    S_CAPTURE,
    S_CHK_FETCH,
    S_CHK,
    S_FETCH,
    S_WRITE,
    S_HOLD,
    S_NEXT,
    S_FIN
  } state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(RD_SETTLE - 1);
  localparam logic [7:0] HOLD_LAST   = 8'(POST_HOLD - 1);
  localparam logic [7:0] TMO_LAST    = 8'(M2_TMO - 1);
  // A fall seen in the first two WRITE cycles happened on raw m2 before ss_we
  // rose (two-flop synchroniser delay), so it cannot have latched our data.
  localparam logic [7:0] FALL_MIN    = 8'd2;
  localparam logic [3:0] IDX_LAST_SAVE    = 4'd15;
  localparam logic [3:0] IDX_LAST_RESTORE = 4'd14;  // entry 15 (map_idx) is read-only

  state_t     state;
  logic [3:0] idx;
  logic       dir_q;
  logic [7:0] cnt;
  logic       m2_s1;
  logic       m2_s2;
  logic       m2_prev;
  logic       m2_fall;
  logic       fall_ok;
  logic       fin_done_req;
  logic       fin_err_req;

  // Buffer entry k maps to ss address table[k].
  function automatic logic [7:0] tbl_addr(input logic [3:0] k);
    logic [7:0] a;
    case (k)
      4'd11:   a = 8'd16;
      4'd12:   a = 8'd17;
      4'd13:   a = 8'd18;
      4'd14:   a = 8'd19;
      4'd15:   a = 8'd127;
      default: a = {4'd0, k};
    endcase
    return a;
  endfunction

  assign m2_fall = m2_prev & ~m2_s2;
  assign fall_ok = m2_fall && (cnt >= FALL_MIN);

  // Decide when the sequence ends this cycle, and whether it ends well or badly.
  always_comb begin
    fin_done_req = 1'b0;
    fin_err_req  = 1'b0;
    case (state)
      S_NEXT:  fin_done_req = dir_q ? (idx == IDX_LAST_RESTORE) : (idx == IDX_LAST_SAVE);
      S_CHK:   fin_err_req  = (buf_rdat != MAP_IDX);
      S_WRITE: fin_err_req  = !fall_ok && (cnt == TMO_LAST);
      default: begin
        fin_done_req = 1'b0;
        fin_err_req  = 1'b0;
      end
    endcase
  end

  // Sequencer FSM with registered outputs; the m2 synchroniser lives here too.
  always_ff @(posedge clk) begin
    if (map_rst) begin
      state    <= S_IDLE;
      idx      <= 4'd0;
      dir_q    <= 1'b0;
      cnt      <= 8'd0;
      m2_s1    <= 1'b0;
      m2_s2    <= 1'b0;
      m2_prev  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      ss_act   <= 1'b0;
      ss_we    <= 1'b0;
      ss_addr  <= 8'd0;
      ss_wdat  <= 8'd0;
      buf_addr <= 4'd0;
      buf_we   <= 1'b0;
      buf_wdat <= 8'd0;
    end else begin
      m2_s1   <= m2;
      m2_s2   <= m2_s1;
      m2_prev <= m2_s2;
      done    <= 1'b0;
      err     <= 1'b0;
      buf_we  <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            idx    <= 4'd0;
            dir_q  <= dir;
            cnt    <= 8'd0;
            busy   <= 1'b1;
            ss_act <= 1'b1;
            if (dir) begin
              buf_addr <= 4'd15;
              state    <= S_CHK_FETCH;
            end else begin
              ss_addr <= tbl_addr(4'd0);
              state   <= S_SETTLE;
            end
          end
        end

        S_SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            cnt   <= 8'd0;
            state <= S_CAPTURE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        S_CAPTURE: begin
          buf_we   <= 1'b1;
          buf_addr <= idx;
          buf_wdat <= ss_rdat;
          state    <= S_NEXT;
        end

        // Entry 15 is on the buffer now; start presenting entry 0 so that its
        // data is already on buf_rdat by the end of FETCH.
        S_CHK_FETCH: begin
          buf_addr <= 4'd0;
          state    <= S_CHK;
        end

        S_CHK: begin
          idx   <= 4'd0;
          state <= S_FETCH;
        end

        S_FETCH: begin
          ss_wdat <= buf_rdat;
          ss_addr <= tbl_addr(idx);
          ss_we   <= 1'b1;
          cnt     <= 8'd0;
          state   <= S_WRITE;
        end

        S_WRITE: begin
          if (fall_ok) begin
            cnt   <= 8'd0;
            state <= S_HOLD;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        S_HOLD: begin
          if (cnt == HOLD_LAST) begin
            ss_we    <= 1'b0;
            cnt      <= 8'd0;
            buf_addr <= idx + 4'd1;  // prefetch the next entry during NEXT
            state    <= S_NEXT;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        S_NEXT: begin
          if (!fin_done_req) begin
            idx <= idx + 4'd1;
            if (dir_q) begin
              state <= S_FETCH;
            end else begin
              ss_addr <= tbl_addr(idx + 4'd1);
              cnt     <= 8'd0;
              state   <= S_SETTLE;
            end
          end
        end

        S_FIN: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase

      // Leaving the sequence: everything returns to its idle value during FIN,
      // and exactly one of done/err pulses there.
      if (fin_done_req || fin_err_req) begin
        state    <= S_FIN;
        busy     <= 1'b0;
        ss_act   <= 1'b0;
        ss_we    <= 1'b0;
        ss_addr  <= 8'd0;
        ss_wdat  <= 8'd0;
        buf_addr <= 4'd0;
        buf_wdat <= 8'd0;
        cnt      <= 8'd0;
        done     <= fin_done_req;
        err      <= fin_err_req;
      end
    end
  end

endmodule
